fifo_wr_ctrl: RTL and testbench
===============================

# fifo_wr_ctrl

Write-side controller for the asynchronous FIFO. It sits in the write clock domain and accepts words from a valid/ready producer. It drives the dual-port memory write enable and address, and publishes a Gray-coded write pointer for the read domain. It synchronizes the read domain's Gray read pointer internally and derives full, almost-full, free-slot count and a sticky overflow flag from it.

## Interface
- ADDRSIZE, 3: memory address width. Depth DEPTH = 2^ADDRSIZE.
- AFULL_LEVEL, 6: occupancy at or above which walmost_full asserts. Legal range 1..DEPTH.
- SYNC_STAGES, 2: flip-flop stages on the incoming rptr. Minimum 2.

- wclk  in  1  write-domain clock; all logic is on the rising edge.
- wrst  in  1  synchronous, active-high reset.
- wvalid  in  1  producer presents a word this cycle.
- wready  out  1  equals ~wfull. A write occurs on any cycle with wvalid & wready.
- wclken  out  1  memory write enable, combinational: wvalid & ~wfull.
- waddr  out  ADDRSIZE  memory write address, combinational: wbin[ADDRSIZE-1:0].
- wptr  out  ADDRSIZE+1  registered Gray write pointer, sent to the read domain.
- rptr  in  ADDRSIZE+1  Gray read pointer from the read domain, asynchronous to wclk.
- wfull  out  1  registered full flag.
- walmost_full  out  1  registered; asserts when occupancy >= AFULL_LEVEL.
- wfree  out  ADDRSIZE+1  registered count of free slots, 0..DEPTH. The count is conservative.
- wovf  out  1  sticky overflow: a write was attempted while full.
- wovf_clr  in  1  clears wovf.

## Operation
- State: wbin (ADDRSIZE+1 bit binary), wptr, and the rptr synchronizer chain sync[0..SYNC_STAGES-1]. rq_rptr is the last synchronizer stage.
- Next pointer:
  - wbinnext = wbin + (wvalid & ~wfull), modulo 2^(ADDRSIZE+1).
  - wgraynext = (wbinnext >> 1) ^ wbinnext.
- Read-pointer conversion: rq_rbin = Gray-to-binary(rq_rptr), computed MSB-first with an XOR prefix.
- Occupancy: wcount_next = wbinnext - rq_rbin, ADDRSIZE+1 bits, modulo arithmetic. Its range is 0..DEPTH.
- Registered updates on each wclk edge when wrst = 0:
  - wbin <= wbinnext
  - wptr <= wgraynext
  - wfull <= (wgraynext == {~rq_rptr[ADDRSIZE:ADDRSIZE-1], rq_rptr[ADDRSIZE-2:0]})
  - walmost_full <= (wcount_next >= AFULL_LEVEL)
  - wfree <= DEPTH - wcount_next
- Consistency invariant: wfull == (wfree == 0) on every cycle.
- Write while full: wvalid with wfull = 1 is not a write.
  - wclken = 0; wbin and wptr hold.
  - wovf <= 1 on the next edge.
- wovf update: wovf <= (wovf & ~wovf_clr) | (wvalid & wfull). If set and clear coincide, set wins.
- Wrap-around:
  - wbin wraps from 2^(ADDRSIZE+1)-1 to 0 with no special casing.
  - Full detection relies on the two inverted Gray MSBs, so it is correct across wraps.
- Reset: synchronous, with priority over every other input, including wvalid and wovf_clr. An asserted reset aborts any in-progress fill. Values after reset:
  - wbin = 0, wptr = 0, all synchronizer stages = 0
  - wfull = 0, walmost_full = 0, wfree = DEPTH, wovf = 0
  - wready = 1 once wrst deasserts
- The read domain must be reset in the same system reset sequence. This block does not check that.

## Timing
- Write acceptance: combinational. A word is accepted on the edge where wvalid & wready = 1.
- wptr and the flags reflect that write immediately after the same edge, with zero-cycle flag latency.
- Becoming full: wfull asserts right after the edge that accepts the DEPTH-th unread word. The same edge sets wfree = 0.
- Read-side release: a change on rptr presented before edge t is captured into sync[0] at t and reaches rq_rptr at edge t+SYNC_STAGES-1.
  - wfull, walmost_full and wfree update at edge t+SYNC_STAGES.
  - With default parameters, that is the third wclk edge after the change.
- Conservatism: during the synchronizer lag, the flags can show the FIFO fuller than it really is, never emptier. An overflow of real memory must be impossible.
- The rptr input changes by one Gray bit per read-domain step. This block only requires Gray-coded input and does not enforce one-step changes.

## Test plan
- Reset: hold wrst for 2 cycles with wvalid = 1 and rptr = 0.
  - Required: wptr = 0, wfull = 0, walmost_full = 0, wfree = 8, wovf = 0, wready = 1.
  - No write occurs during reset.
- Fill with rptr held at 0 and wvalid = 1 for 8 cycles:
  - wptr sequence: 1, 3, 2, 6, 7, 5, 4, 12.
  - waddr sequence: 0..7.
  - walmost_full rises after the 6th write; wfull = 1 and wfree = 0 after the 8th write.
  - wready = 0 on the 9th cycle.
- Overflow: with the FIFO full, drive wvalid for 3 cycles.
  - Required: wclken = 0, wptr stays 12, wovf = 1 and sticky.
  - Then pulse wovf_clr for 1 cycle with wvalid = 1: wovf stays 1 (set wins).
  - Then pulse wovf_clr with wvalid = 0: wovf = 0.
- Drain release: from full, set rptr = 2 (Gray for binary 3).
  - Required: wfull and walmost_full stay 1 for 2 edges.
  - At the 3rd edge: wfull = 0, wfree = 3, walmost_full = 0 (occupancy 5).
- Wrap-around: 40 writes, with rptr following the write pointer 4 entries behind.
  - Required: wbin wraps twice; wfull never asserts; wfree = 4 in steady state.
  - Then freeze rptr: wfull asserts after exactly 4 more writes.
- Mid-fill reset: after 5 writes, assert wrst for 1 cycle while wvalid = 1.
  - Required: all outputs return to reset values on that edge.
  - The next write uses waddr = 0.

Source files
------------

// File: rtl/fifo_wr_ctrl.sv
// Write-side controller of an asynchronous FIFO: it accepts producer words, drives the memory write port,
// publishes a Gray write pointer and derives full/almost-full/free/overflow from the synchronized read pointer.
module fifo_wr_ctrl #(
    parameter int ADDRSIZE    = 3,
    parameter int AFULL_LEVEL = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic                wclk,
    input  logic                wrst,
    input  logic                wvalid,
    output logic                wready,
    output logic                wclken,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE:0]   wptr,
    input  logic [ADDRSIZE:0]   rptr,
    output logic                wfull,
    output logic                walmost_full,
    output logic [ADDRSIZE:0]   wfree,
    output logic                wovf,
    input  logic                wovf_clr
);

    localparam int              PW    = ADDRSIZE + 1;
    localparam logic [PW-1:0]   DEPTH = PW'(1 << ADDRSIZE);
    localparam logic [PW-1:0]   AFULL = PW'(AFULL_LEVEL);

    logic [PW-1:0] wbin;
    logic [PW-1:0] rptr_sync [SYNC_STAGES];
    logic [PW-1:0] rq_rptr;
    logic [PW-1:0] rq_rbin;
    logic [PW-1:0] wbinnext;
    logic [PW-1:0] wgraynext;
    logic [PW-1:0] wcount_next;
    logic [PW-1:0] full_pattern;

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return (b >> 1) ^ b;
    endfunction

    // MSB-first XOR prefix: each binary bit is the parity of all Gray bits above and including it
    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    assign rq_rptr      = rptr_sync[SYNC_STAGES-1];
    assign rq_rbin      = gray2bin(rq_rptr);
    assign wclken       = wvalid & ~wfull;
    assign wready       = ~wfull;
    assign waddr        = wbin[ADDRSIZE-1:0];
    assign wbinnext     = wbin + PW'(wclken);
    assign wgraynext    = bin2gray(wbinnext);
    // The stale read pointer only ever lags, so this occupancy can overstate but never understate
    assign wcount_next  = wbinnext - rq_rbin;
    assign full_pattern = {~rq_rptr[PW-1:PW-2], rq_rptr[PW-3:0]};

    // Stage boundary: rptr synchronizer chain, one flop per stage
    always_ff @(posedge wclk) begin
        if (wrst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                rptr_sync[i] <= '0;
            end
        end else begin
            rptr_sync[0] <= rptr;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                rptr_sync[i] <= rptr_sync[i-1];
            end
        end
    end

    // Stage boundary: write pointer and flags, all updated together from the next-pointer value
    always_ff @(posedge wclk) begin
        if (wrst) begin
            wbin         <= '0;
            wptr         <= '0;
            wfull        <= 1'b0;
            walmost_full <= 1'b0;
            wfree        <= DEPTH;
            wovf         <= 1'b0;
        end else begin
            wbin         <= wbinnext;
            wptr         <= wgraynext;
            wfull        <= (wgraynext == full_pattern);
            walmost_full <= (wcount_next >= AFULL);
            wfree        <= DEPTH - wcount_next;
            wovf         <= (wovf & ~wovf_clr) | (wvalid & wfull);
        end
    end

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed bench for fifo_wr_ctrl: a vector table for fill/overflow/drain, then hand-written
// sequences for reset, wrap-around with a trailing reader, and reset in the middle of a fill.
module tb_fifo_wr_ctrl;

    logic       wclk = 1'b0;
    logic       wrst;
    logic       wvalid;
    logic       wready;
    logic       wclken;
    logic [2:0] waddr;
    logic [3:0] wptr;
    logic [3:0] rptr;
    logic       wfull;
    logic       walmost_full;
    logic [3:0] wfree;
    logic       wovf;
    logic       wovf_clr;

    int tests  = 0;
    int failed = 0;

    always #5 wclk = ~wclk;

    fifo_wr_ctrl #(.ADDRSIZE(3), .AFULL_LEVEL(6), .SYNC_STAGES(2)) dut (
        .wclk(wclk), .wrst(wrst), .wvalid(wvalid), .wready(wready), .wclken(wclken),
        .waddr(waddr), .wptr(wptr), .rptr(rptr), .wfull(wfull), .walmost_full(walmost_full),
        .wfree(wfree), .wovf(wovf), .wovf_clr(wovf_clr)
    );

    typedef struct {
        logic       wvalid;
        logic       wovf_clr;
        logic [3:0] rptr;
        logic       exp_wclken;
        logic [2:0] exp_waddr;
        logic       exp_wready;
        logic [3:0] exp_wptr;
        logic       exp_wfull;
        logic       exp_af;
        logic [3:0] exp_wfree;
        logic       exp_wovf;
    } vec_t;

    vec_t vecs[16];

    function automatic vec_t mk(input logic v, input logic clr, input logic [3:0] rp,
                                input logic en, input logic [2:0] ad, input logic rdy,
                                input logic [3:0] wp, input logic fu, input logic af,
                                input logic [3:0] fr, input logic ov);
        vec_t r;
        r.wvalid = v;  r.wovf_clr = clr; r.rptr = rp;
        r.exp_wclken = en; r.exp_waddr = ad; r.exp_wready = rdy;
        r.exp_wptr = wp; r.exp_wfull = fu; r.exp_af = af; r.exp_wfree = fr; r.exp_wovf = ov;
        return r;
    endfunction

    function automatic logic [3:0] gray4(input int b);
        logic [3:0] v;
        v = 4'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s [%0d]: got %0h, expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge wclk);
        wvalid   = v.wvalid;
        wovf_clr = v.wovf_clr;
        rptr     = v.rptr;
        #1;
        chk("wclken", idx, 32'(wclken), 32'(v.exp_wclken));
        chk("waddr",  idx, 32'(waddr),  32'(v.exp_waddr));
        chk("wready", idx, 32'(wready), 32'(v.exp_wready));
        @(posedge wclk);
        #1;
        chk("wptr",         idx, 32'(wptr),         32'(v.exp_wptr));
        chk("wfull",        idx, 32'(wfull),        32'(v.exp_wfull));
        chk("walmost_full", idx, 32'(walmost_full), 32'(v.exp_af));
        chk("wfree",        idx, 32'(wfree),        32'(v.exp_wfree));
        chk("wovf",         idx, 32'(wovf),         32'(v.exp_wovf));
    endtask

    task automatic do_reset();
        @(negedge wclk);
        wrst = 1'b1; wvalid = 1'b0; wovf_clr = 1'b0; rptr = 4'd0;
        @(negedge wclk);
        wrst = 1'b0;
    endtask

    task automatic write_one(input logic [3:0] rp);
        @(negedge wclk);
        wvalid = 1'b1;
        rptr   = rp;
        @(posedge wclk);
        #1;
    endtask

    initial begin
        logic [3:0] fill_gray [8];
        fill_gray = '{4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4, 4'd12};
        // Fill from empty with the reader parked at 0
        for (int k = 1; k <= 8; k++) begin
            vecs[k-1] = mk(1'b1, 1'b0, 4'd0, 1'b1, 3'(k-1), 1'b1, fill_gray[k-1],
                           (k == 8), (k >= 6), 4'(8 - k), 1'b0);
        end
        // Writes attempted while full
        for (int k = 8; k < 11; k++) begin
            vecs[k] = mk(1'b1, 1'b0, 4'd0, 1'b0, 3'd0, 1'b0, 4'd12, 1'b1, 1'b1, 4'd0, 1'b1);
        end
        vecs[11] = mk(1'b1, 1'b1, 4'd0, 1'b0, 3'd0, 1'b0, 4'd12, 1'b1, 1'b1, 4'd0, 1'b1);
        vecs[12] = mk(1'b0, 1'b1, 4'd0, 1'b0, 3'd0, 1'b0, 4'd12, 1'b1, 1'b1, 4'd0, 1'b0);
        // Reader advances to binary 3 (Gray 2); release becomes visible on the third edge
        vecs[13] = mk(1'b0, 1'b0, 4'd2, 1'b0, 3'd0, 1'b0, 4'd12, 1'b1, 1'b1, 4'd0, 1'b0);
        vecs[14] = mk(1'b0, 1'b0, 4'd2, 1'b0, 3'd0, 1'b0, 4'd12, 1'b1, 1'b1, 4'd0, 1'b0);
        vecs[15] = mk(1'b0, 1'b0, 4'd2, 1'b0, 3'd0, 1'b0, 4'd12, 1'b0, 1'b0, 4'd3, 1'b0);

        wrst = 1'b1; wvalid = 1'b1; wovf_clr = 1'b0; rptr = 4'd0;
        repeat (2) @(posedge wclk);
        #1;
        chk("rst_wptr",  0, 32'(wptr),         32'd0);
        chk("rst_wfull", 0, 32'(wfull),        32'd0);
        chk("rst_af",    0, 32'(walmost_full), 32'd0);
        chk("rst_wfree", 0, 32'(wfree),        32'd8);
        chk("rst_wovf",  0, 32'(wovf),         32'd0);
        @(negedge wclk);
        wrst = 1'b0; wvalid = 1'b0;
        #1;
        chk("rst_wready", 0, 32'(wready), 32'd1);
        chk("rst_waddr",  0, 32'(waddr),  32'd0);

        for (int i = 0; i < 16; i++) begin
            apply(vecs[i], i);
        end

        // Reader trails so the write side, including sync lag, sees 4 entries outstanding
        do_reset();
        for (int n = 0; n < 40; n++) begin
            @(negedge wclk);
            wvalid = 1'b1;
            rptr   = gray4((n >= 1) ? n - 1 : 0);
            #1;
            chk("wrap_waddr", n, 32'(waddr), 32'(n % 8));
            @(posedge wclk);
            #1;
            chk("wrap_wfull", n, 32'(wfull), 32'd0);
            chk("wrap_wptr",  n, 32'(wptr),  32'(gray4(n + 1)));
            if (n >= 6) chk("wrap_wfree", n, 32'(wfree), 32'd4);
        end
        // Freeze the reader 4 entries behind: the fourth write fills the FIFO
        for (int j = 0; j < 4; j++) begin
            write_one(gray4(36));
            chk("frz_wfull", j, 32'(wfull), 32'(j == 3));
        end
        chk("frz_wfree", 0, 32'(wfree), 32'd0);
        @(negedge wclk);
        #1;
        chk("frz_wclken", 0, 32'(wclken), 32'd0);
        chk("frz_wready", 0, 32'(wready), 32'd0);

        do_reset();
        for (int j = 0; j < 5; j++) write_one(4'd0);
        chk("mid_wptr5", 0, 32'(wptr), 32'd7);
        @(negedge wclk);
        wrst = 1'b1; wvalid = 1'b1;
        @(posedge wclk);
        #1;
        chk("mid_wptr",  0, 32'(wptr),         32'd0);
        chk("mid_wfull", 0, 32'(wfull),        32'd0);
        chk("mid_af",    0, 32'(walmost_full), 32'd0);
        chk("mid_wfree", 0, 32'(wfree),        32'd8);
        chk("mid_wovf",  0, 32'(wovf),         32'd0);
        @(negedge wclk);
        wrst = 1'b0;
        #1;
        chk("mid_waddr",  0, 32'(waddr),  32'd0);
        chk("mid_wclken", 0, 32'(wclken), 32'd1);
        chk("mid_wready", 0, 32'(wready), 32'd1);
        @(posedge wclk);
        #1;
        chk("mid_wptr1", 0, 32'(wptr), 32'd1);
        @(negedge wclk);
        wvalid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
